// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the ID/EX stage and the EX multiply/divide unit.
// The pipeline side is the master; the arithmetic unit is the slave.
interface ex_muldiv_if #(parameter int WIDTH = 32);
    logic [7:0]       aluop_i;
    logic [WIDTH-1:0] reg1_i;
    logic [WIDTH-1:0] reg2_i;
    logic             hold_i;
    logic             cancel_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             done_o;
    logic             stallreq_o;
    logic             busy_o;

    modport master (output aluop_i, reg1_i, reg2_i, hold_i, cancel_i,
                    input  hi_o, lo_o, done_o, stallreq_o, busy_o);
    modport slave  (input  aluop_i, reg1_i, reg2_i, hold_i, cancel_i,
                    output hi_o, lo_o, done_o, stallreq_o, busy_o);
endinterface

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide: one shift-add or restoring-divide step per cycle,
// producing {HI,LO} and stalling the front of the pipe while the iteration runs.
module ex_muldiv #(parameter int WIDTH = 32) (
    input logic       Clk,
    input logic       Rst_n,
    ex_muldiv_if.slave bus
);
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
    localparam int         CW           = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;
    logic               is_div, neg_q, neg_r;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               is_op, start, signed_op, div_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign signed_op = (bus.aluop_i == EXE_MULT_OP) || (bus.aluop_i == EXE_DIV_OP);
    assign div_op    = (bus.aluop_i == EXE_DIV_OP)  || (bus.aluop_i == EXE_DIVU_OP);
    assign is_op     = signed_op || div_op || (bus.aluop_i == EXE_MULTU_OP);
    assign start     = is_op & ~bus.cancel_i;
    assign a_neg     = signed_op & bus.reg1_i[WIDTH-1];
    assign b_neg     = signed_op & bus.reg2_i[WIDTH-1];
    assign a_mag     = a_neg ? -bus.reg1_i : bus.reg1_i;
    assign b_mag     = b_neg ? -bus.reg2_i : bus.reg2_i;

    // Multiply: acc = {partial, multiplier}; add multiplicand into the top half and shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract, keep if non-negative.
    logic [WIDTH:0]     rem_sh, diff;
    logic               qbit;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_next;
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign diff     = rem_sh - {1'b0, b_q};
    assign qbit     = ~diff[WIDTH];
    assign rem_new  = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_next = {rem_new, acc[WIDTH-2:0], qbit};

    logic [2*WIDTH-1:0] acc_next, mul_res;
    logic [WIDTH-1:0]   q_fix, r_fix;
    assign acc_next = is_div ? div_next : mul_next;
    assign mul_res  = neg_q ? -acc_next : acc_next;
    assign q_fix    = neg_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    assign r_fix    = neg_r ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            count  <= '0;
            b_q    <= '0;
            acc    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (bus.cancel_i) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (div_op && bus.reg2_i == '0) begin
                        state <= DONE;
                        hi_q  <= '0;
                        lo_q  <= '0;
                    end else begin
                        acc    <= {{WIDTH{1'b0}}, a_mag};
                        b_q    <= b_mag;
                        is_div <= div_op;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        count  <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        if (is_div) begin
                            hi_q <= r_fix;
                            lo_q <= q_fix;
                        end else begin
                            hi_q <= mul_res[2*WIDTH-1:WIDTH];
                            lo_q <= mul_res[WIDTH-1:0];
                        end
                    end
                end
                DONE:    if (!bus.hold_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;
    assign bus.done_o     = (state == DONE);
    assign bus.busy_o     = (state == BUSY);
    assign bus.stallreq_o = Rst_n & (((state == IDLE) & start) | ((state == BUSY) & ~bus.cancel_i));
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, signed/unsigned results, hold, cancel and async reset.
module tb_ex_muldiv;
    localparam logic [7:0] NOP   = 8'h00;
    localparam logic [7:0] MULT  = 8'b00011000;
    localparam logic [7:0] MULTU = 8'b00011001;
    localparam logic [7:0] DIV   = 8'b00011010;
    localparam logic [7:0] DIVU  = 8'b00011011;

    logic Clk = 1'b0;
    logic Rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   stalls, dcyc;
    logic seen;

    ex_muldiv_if #(.WIDTH(32)) ifc ();
    ex_muldiv #(.WIDTH(32)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(ifc));

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue an op in an IDLE cycle; return stall-cycle count and the cycle done_o rose.
    task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int st, output int dc);
        ifc.aluop_i = op;
        ifc.reg1_i  = a;
        ifc.reg2_i  = b;
        st = 0;
        dc = -1;
        for (int c = 0; c < 80; c++) begin
            #1;
            if (ifc.done_o) begin
                dc = c;
                break;
            end
            if (ifc.stallreq_o) st++;
            @(posedge Clk); #1;
            if (c == 0) begin
                ifc.reg1_i = ~a;
                ifc.reg2_i = ~b;
            end
        end
    endtask

    task automatic leave_done();
        @(posedge Clk); #1;
        ifc.aluop_i = NOP;
        #1;
        chk("idle_after_done", {63'd0, ifc.done_o}, 64'd0);
    endtask

    initial begin
        Rst_n = 1'b0;
        ifc.aluop_i = NOP; ifc.reg1_i = '0; ifc.reg2_i = '0;
        ifc.hold_i = 1'b0; ifc.cancel_i = 1'b0;
        #12;
        chk("rst_hi", {32'd0, ifc.hi_o}, 64'd0);
        chk("rst_lo", {32'd0, ifc.lo_o}, 64'd0);
        chk("rst_done_busy", {62'd0, ifc.done_o, ifc.busy_o}, 64'd0);
        ifc.aluop_i = MULT;
        #1;
        chk("rst_stallreq", {63'd0, ifc.stallreq_o}, 64'd0);
        ifc.aluop_i = NOP;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;

        do_op(MULT, 32'hFFFFFFFF, 32'h2, stalls, dcyc);
        chk("mult_stalls", 64'(stalls), 64'd33);
        chk("mult_done_cyc", 64'(dcyc), 64'd33);
        chk("mult_hilo", {ifc.hi_o, ifc.lo_o}, 64'hFFFFFFFF_FFFFFFFE);
        leave_done();

        do_op(MULTU, 32'hFFFFFFFF, 32'h2, stalls, dcyc);
        chk("multu_hilo", {ifc.hi_o, ifc.lo_o}, 64'h00000001_FFFFFFFE);
        leave_done();

        do_op(DIVU, 32'd100, 32'd7, stalls, dcyc);
        chk("divu_done_cyc", 64'(dcyc), 64'd33);
        chk("divu_hilo", {ifc.hi_o, ifc.lo_o}, {32'd2, 32'd14});
        leave_done();

        do_op(DIV, 32'hFFFFFFF9, 32'd2, stalls, dcyc);
        chk("div_neg_hilo", {ifc.hi_o, ifc.lo_o}, 64'hFFFFFFFF_FFFFFFFD);
        leave_done();

        do_op(DIV, 32'h80000000, 32'hFFFFFFFF, stalls, dcyc);
        chk("div_ovf_hilo", {ifc.hi_o, ifc.lo_o}, 64'h00000000_80000000);
        leave_done();

        do_op(DIV, 32'd1234, 32'd0, stalls, dcyc);
        chk("div0_done_cyc", 64'(dcyc), 64'd1);
        chk("div0_stalls", 64'(stalls), 64'd1);
        chk("div0_hilo", {ifc.hi_o, ifc.lo_o}, 64'd0);
        leave_done();

        // DONE held for three extra cycles; the op must not restart
        do_op(MULTU, 32'd3, 32'd5, stalls, dcyc);
        ifc.hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            chk("hold_done", {62'd0, ifc.done_o, ifc.busy_o}, 64'd2);
        end
        ifc.hold_i = 1'b0;
        chk("hold_hilo", {ifc.hi_o, ifc.lo_o}, 64'd15);
        leave_done();
        #1;
        chk("hold_no_restart", {63'd0, ifc.stallreq_o}, 64'd0);

        // back-to-back: DIVU enters EX during the MULT DONE cycle
        do_op(MULT, 32'd3, 32'hFFFFFFFC, stalls, dcyc);
        chk("b2b_mult_hilo", {ifc.hi_o, ifc.lo_o}, 64'hFFFFFFFF_FFFFFFF4);
        ifc.aluop_i = DIVU; ifc.reg1_i = 32'd50; ifc.reg2_i = 32'd8;
        #1;
        chk("b2b_done_nostall", {63'd0, ifc.stallreq_o}, 64'd0);
        @(posedge Clk); #1;
        do_op(DIVU, 32'd50, 32'd8, stalls, dcyc);
        chk("b2b_divu_cyc", 64'(dcyc), 64'd33);
        chk("b2b_divu_hilo", {ifc.hi_o, ifc.lo_o}, {32'd2, 32'd6});
        leave_done();

        // cancel at BUSY count 10 (cycle 11 after start)
        ifc.aluop_i = MULTU; ifc.reg1_i = 32'd7; ifc.reg2_i = 32'd9;
        for (int i = 0; i < 11; i++) begin
            @(posedge Clk); #1;
        end
        chk("cancel_busy_before", {63'd0, ifc.busy_o}, 64'd1);
        ifc.cancel_i = 1'b1;
        #1;
        chk("cancel_stallreq", {63'd0, ifc.stallreq_o}, 64'd0);
        @(posedge Clk); #1;
        ifc.cancel_i = 1'b0;
        ifc.aluop_i = NOP;
        #1;
        chk("cancel_idle", {62'd0, ifc.done_o, ifc.busy_o}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (ifc.done_o) seen = 1'b1;
        end
        chk("cancel_never_done", {63'd0, seen}, 64'd0);
        chk("cancel_hilo_kept", {ifc.hi_o, ifc.lo_o}, {32'd2, 32'd6});

        // asynchronous reset in the middle of an iteration
        ifc.aluop_i = DIVU; ifc.reg1_i = 32'd1000; ifc.reg2_i = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
        end
        chk("arst_busy_before", {63'd0, ifc.busy_o}, 64'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_hilo", {ifc.hi_o, ifc.lo_o}, 64'd0);
        chk("arst_flags", {61'd0, ifc.done_o, ifc.busy_o, ifc.stallreq_o}, 64'd0);
        ifc.aluop_i = NOP;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        do_op(MULTU, 32'd6, 32'd7, stalls, dcyc);
        chk("arst_new_cyc", 64'(dcyc), 64'd33);
        chk("arst_new_hilo", {ifc.hi_o, ifc.lo_o}, 64'd42);
        leave_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
